uart_loader: RTL and testbench

Program loader sitting directly downstream of the UART receiver. Consumes the receiver's one-cycle `done` strobe and 8-bit `out` byte, parses a framed image (sync byte, 16-bit big-endian length, payload, optional XOR checksum) and writes each payload byte to instruction memory through a simple write port. Reports completion or error with single-cycle pulses; an inter-byte timeout keeps a broken transfer from stalling the loader.

---
 rtl/uart_loader_pkg.sv | 14 +
 rtl/uart_timeout.sv | 29 ++
 rtl/uart_loader.sv | 166 ++++++++++++++++
 tb/tb_uart_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StCksum
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and pulses
// expired when the count reaches CYCLES-1. CYCLES must be at least 2.
module uart_timeout #(
    parameter int unsigned CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // Fires on the cycle whose increment would reach CYCLES-1, so the registered
    // error lands exactly CYCLES cycles after the last byte.
    assign expired = enable && !clear && (cnt_q == CW'(CYCLES - 2));

    always_ff @(posedge clk) begin
        if (rst || clear || expired) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_loader.sv
// Framed program loader behind the UART receiver: sync, 16-bit length, payload,
// and an optional XOR checksum byte enabled by UART_LOADER_CHECKSUM_EN.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_done,
    input  logic [7:0]            rx_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int unsigned CW      = ADDR_WIDTH + 1;
    localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_WIDTH;

    loader_state_t         state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  expired;
    logic [15:0]           len_rx;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]            acc_q, acc_d;
`endif

    assign len_rx = {len_q[15:8], rx_data};

    uart_timeout #(
        .CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_done),
        .enable (busy),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
        acc_d   = acc_q;
`endif
        if (rx_done) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = StLenHi;
`ifdef UART_LOADER_CHECKSUM_EN
                        acc_d   = 8'h00;
`endif
                    end
                end
                StLenHi: begin
                    len_d[15:8] = rx_data;
                    state_d     = StLenLo;
`ifdef UART_LOADER_CHECKSUM_EN
                    acc_d       = acc_q ^ rx_data;
`endif
                end
                StLenLo: begin
                    len_d = len_rx;
                    cnt_d = '0;
`ifdef UART_LOADER_CHECKSUM_EN
                    acc_d = acc_q ^ rx_data;
`endif
                    if ({16'h0000, len_rx} > MAX_LEN) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else if (len_rx == 16'h0000) begin
`ifdef UART_LOADER_CHECKSUM_EN
                        state_d = StCksum;
`else
                        done_d  = 1'b1;
                        state_d = StIdle;
`endif
                    end else begin
                        state_d = StData;
                    end
                end
                StData: begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_WIDTH-1:0];
                    wdata_d = rx_data;
                    cnt_d   = cnt_q + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                    acc_d   = acc_q ^ rx_data;
`endif
                    if (32'(cnt_d) == 32'(len_q)) begin
`ifdef UART_LOADER_CHECKSUM_EN
                        state_d = StCksum;
`else
                        done_d  = 1'b1;
                        state_d = StIdle;
`endif
                    end
                end
                StCksum: begin
`ifdef UART_LOADER_CHECKSUM_EN
                    done_d = (rx_data == acc_q);
                    err_d  = (rx_data != acc_q);
`endif
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (expired) begin
            err_d   = 1'b1;
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef UART_LOADER_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign busy      = (state_q != StIdle);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader (ADDR_WIDTH=4, TIMEOUT_CYCLES=50); follows
// UART_LOADER_CHECKSUM_EN the same way the design does.
module tb_uart_loader;

    localparam int AW = 4;
`ifdef UART_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_done = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          load_done;
    logic          load_err;

    uart_loader #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .load_done(load_done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         npre;
        logic [7:0] pre[3];
        logic [15:0] len;
        int         plen;
        logic [7:0] pay[16];
        bit         send_ck;
        logic [7:0] ck;
        int         exp_writes;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[6];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int last_rx = 0;
    int err_busy = 0;
    int wq_addr[$];
    int wq_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Passive observer, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_done) last_rx = cyc;
        if (mem_we) begin
            wq_addr.push_back(int'(mem_addr));
            wq_data.push_back(int'(mem_wdata));
        end
        if (load_done) done_cnt++;
        if (load_err) begin
            err_cnt++;
            err_cyc = cyc;
            err_busy = int'(busy);
        end
        if (load_done || load_err) begin
            n_checks++;
            if (load_done && load_err) begin
                n_fail++;
                $display("FAIL pulse_exclusive: load_done=1 load_err=1 at cycle %0d, required not both", cyc);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_done = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic clear_obs();
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic check_writes(input string tag, input int n, input logic [7:0] exp_data[16]);
        check($sformatf("%s_nwrites", tag), wq_addr.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < wq_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, i), wq_addr[i], i);
                check($sformatf("%s_data%0d", tag, i), wq_data[i], int'(exp_data[i]));
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        clear_obs();
        for (int i = 0; i < v.npre; i++) send_byte(v.pre[i]);
        send_byte(8'hA5);
        send_byte(v.len[15:8]);
        send_byte(v.len[7:0]);
        for (int i = 0; i < v.plen; i++) send_byte(v.pay[i]);
        if (CK_EN && v.send_ck) send_byte(v.ck);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_writes(tag, v.exp_writes, v.pay);
        check({tag, "_done"}, done_cnt, v.exp_done);
        check({tag, "_err"}, err_cnt, v.exp_err);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    logic [7:0] exp_pay[16];
    int waited;

    initial begin
        foreach (vecs[i]) begin
            vecs[i].npre = 0;
            vecs[i].pre = '{default: 8'h00};
            vecs[i].pay = '{default: 8'h00};
            vecs[i].send_ck = 1'b1;
        end
        // Good 3-byte frame, checksum 00^03^11^22^33 = 03.
        vecs[0].len = 16'h0003; vecs[0].plen = 3;
        vecs[0].pay[0] = 8'h11; vecs[0].pay[1] = 8'h22; vecs[0].pay[2] = 8'h33;
        vecs[0].ck = 8'h03; vecs[0].exp_writes = 3; vecs[0].exp_done = 1; vecs[0].exp_err = 0;
        // Same frame, wrong checksum.
        vecs[1] = vecs[0];
        vecs[1].ck = 8'h04;
        vecs[1].exp_done = CK_EN ? 0 : 1;
        vecs[1].exp_err  = CK_EN ? 1 : 0;
        // Leading junk, then 1-byte frame with checksum 01^7E = 7F.
        vecs[2].npre = 3; vecs[2].pre[0] = 8'h00; vecs[2].pre[1] = 8'hFF; vecs[2].pre[2] = 8'h5A;
        vecs[2].len = 16'h0001; vecs[2].plen = 1; vecs[2].pay[0] = 8'h7E; vecs[2].ck = 8'h7F;
        vecs[2].exp_writes = 1; vecs[2].exp_done = 1; vecs[2].exp_err = 0;
        // Length 17 exceeds 2**4.
        vecs[3].len = 16'h0011; vecs[3].plen = 0; vecs[3].send_ck = 1'b0; vecs[3].ck = 8'h00;
        vecs[3].exp_writes = 0; vecs[3].exp_done = 0; vecs[3].exp_err = 1;
        // Full 16-byte image 30..3F; XOR of payload is 00, so checksum = 10.
        vecs[4].len = 16'h0010; vecs[4].plen = 16;
        for (int i = 0; i < 16; i++) vecs[4].pay[i] = 8'h30 + 8'(i);
        vecs[4].ck = 8'h10; vecs[4].exp_writes = 16; vecs[4].exp_done = 1; vecs[4].exp_err = 0;
        // Zero-length frame.
        vecs[5].len = 16'h0000; vecs[5].plen = 0; vecs[5].ck = 8'h00;
        vecs[5].exp_writes = 0; vecs[5].exp_done = 1; vecs[5].exp_err = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_mem_wdata", int'(mem_wdata), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_load_done", int'(load_done), 0);
        check("rst_load_err", int'(load_err), 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Inter-byte timeout after one of two payload bytes.
        clear_obs();
        send_byte(8'hA5);
        @(negedge clk);
        check("to_busy_after_sync", int'(busy), 1);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hAA);
        waited = 0;
        while (err_cnt == 0 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("to_err_count", err_cnt, 1);
        check("to_latency", err_cyc - last_rx, 50);
        check("to_busy_at_err", err_busy, 0);
        check("to_done", done_cnt, 0);
        exp_pay = '{default: 8'h00};
        exp_pay[0] = 8'hAA;
        check_writes("to", 1, exp_pay);

        // Reset in the middle of a 4-byte frame.
        clear_obs();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_mem_we", int'(mem_we), 0);
        check("mid_rst_mem_addr", int'(mem_addr), 0);
        check("mid_rst_mem_wdata", int'(mem_wdata), 0);
        check("mid_rst_busy", int'(busy), 0);
        exp_pay = '{default: 8'h00};
        exp_pay[0] = 8'h01;
        exp_pay[1] = 8'h02;
        check_writes("mid_pre", 2, exp_pay);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("mid_rst_no_done", done_cnt, 0);
        check("mid_rst_no_err", err_cnt, 0);

        // Fresh frame after reset, checksum 02^55^66 = 31.
        clear_obs();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h55);
        send_byte(8'h66);
        if (CK_EN) send_byte(8'h31);
        repeat (4) @(posedge clk);
        @(negedge clk);
        exp_pay = '{default: 8'h00};
        exp_pay[0] = 8'h55;
        exp_pay[1] = 8'h66;
        check_writes("post_rst", 2, exp_pay);
        check("post_rst_done", done_cnt, 1);
        check("post_rst_err", err_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
